// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch front end.
//   Issues word-aligned fetch requests, tracks up to two outstanding
//   addresses, buffers returned instructions in a 2-entry FIFO and hands
//   the head entry to the IF/ID register. Redirects flush the buffer and
//   arrange for stale in-order responses to be dropped.
// Configuration macro: IF_FETCH_RSP_BYPASS_EN
//   defined   -> a response arriving with an empty FIFO is presented on
//                if_* in the same cycle and stored only if not consumed.
//   undefined -> if_* come straight from the FIFO registers.
// Ports:
//   clk, resetManual (sync, active-low)
//   PCWrite          fetch enable from hazard unit
//   IF_ID_Write      downstream ready (pops head when if_valid)
//   redirect_valid / redirect_pc   taken branch/jump target
//   imem_req_valid / imem_req_ready / imem_req_addr   fetch request
//   imem_rsp_valid / imem_rsp_data                    in-order response
//   if_valid / if_instruction / if_pc / if_pcplus4    head entry
//   PCOutput         current fetch PC
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetManual,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pcplus4,
  output logic [31:0] PCOutput
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 2;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   infl;
  logic [CW-1:0]   drop;
  logic [XLEN-1:0] buf_pc0, buf_pc1, buf_ins0, buf_ins1;
  logic [XLEN-1:0] infl_pc0, infl_pc1;

  logic            rsp_live;
  logic            byp;
  logic            pop;
  logic            pop_buf;
  logic            push_buf;
  logic            fire;
  logic [2:0]      busy;
  logic [2:0]      outstanding;
  logic [CW-1:0]   drop_redirect;
  logic [CW-1:0]   push_slot;

  logic            unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_req_addr = fetch_pc;
  assign PCOutput      = fetch_pc;

  // Head selection, request gating and bookkeeping terms.
  always_comb begin
    rsp_live = imem_rsp_valid && (infl != '0) && (drop == '0);
`ifdef IF_FETCH_RSP_BYPASS_EN
    byp = rsp_live && (occ == '0) && !redirect_valid;
`else
    byp = 1'b0;
`endif
    if_valid       = (occ != '0) || byp;
    if_pc          = byp ? infl_pc0 : buf_pc0;
    if_instruction = byp ? imem_rsp_data : buf_ins0;
    if_pcplus4     = if_pc + 32'd4;
    pop            = if_valid && IF_ID_Write;
    pop_buf        = pop && !byp;
    push_buf       = rsp_live && !(byp && IF_ID_Write);
    push_slot      = occ - 2'(pop_buf);
    // A same-cycle pop frees its slot, which keeps a 1-cycle memory streaming.
    busy           = 3'(occ) + 3'(infl) - 3'(pop);
    imem_req_valid = resetManual && PCWrite && !redirect_valid && (busy < 3'd2);
    fire           = imem_req_valid && imem_req_ready;
    // Everything still owed by memory becomes a drop on redirect; a response
    // landing in the redirect cycle settles one of them immediately.
    outstanding    = 3'(drop) + 3'(infl)
                   - 3'(imem_rsp_valid && ((drop != '0) || (infl != '0)));
    drop_redirect  = (outstanding > 3'd2) ? 2'd2 : 2'(outstanding);
  end

  // PC, in-flight address queue, drop counter and instruction FIFO.
  always_ff @(posedge clk) begin
    if (!resetManual) begin
      fetch_pc <= RESET_PC;
      occ      <= '0;
      infl     <= '0;
      drop     <= '0;
      buf_pc0  <= '0;
      buf_pc1  <= '0;
      buf_ins0 <= '0;
      buf_ins1 <= '0;
      infl_pc0 <= '0;
      infl_pc1 <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      occ      <= '0;
      infl     <= '0;
      drop     <= drop_redirect;
    end else begin
      if (imem_rsp_valid && (drop != '0)) drop <= drop - 2'd1;

      if (fire) fetch_pc <= fetch_pc + 32'd4;

      // In-flight queue: retire oldest on response, append on request.
      if (rsp_live) begin
        infl_pc0 <= infl_pc1;
        if (fire) begin
          if (infl == 2'd1) infl_pc0 <= fetch_pc;
          else              infl_pc1 <= fetch_pc;
        end
      end else if (fire) begin
        if (infl == '0) infl_pc0 <= fetch_pc;
        else            infl_pc1 <= fetch_pc;
      end
      infl <= infl + 2'(fire) - 2'(rsp_live);

      // Instruction FIFO: shift on pop, write tail after the shift.
      if (pop_buf) begin
        buf_pc0  <= buf_pc1;
        buf_ins0 <= buf_ins1;
      end
      if (push_buf) begin
        if (push_slot == '0) begin
          buf_pc0  <= infl_pc0;
          buf_ins0 <= imem_rsp_data;
        end else begin
          buf_pc1  <= infl_pc0;
          buf_ins1 <= imem_rsp_data;
        end
      end
      occ <= occ + 2'(push_buf) - 2'(pop_buf);
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios followed by a randomized
// phase, all compared against a queue-based reference model and a simple
// in-order instruction memory with configurable latency.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0040;
`ifdef IF_FETCH_RSP_BYPASS_EN
  localparam int          FIRST_LAT = 2;
  localparam logic [31:0] STALL_PC  = 32'h0000_0008;
`else
  localparam int          FIRST_LAT = 3;
  localparam logic [31:0] STALL_PC  = 32'h0000_000C;
`endif

  logic        clk;
  logic        resetManual, PCWrite, IF_ID_Write, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_instruction, if_pc, if_pcplus4, PCOutput;

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .resetManual(resetManual), .PCWrite(PCWrite),
    .IF_ID_Write(IF_ID_Write), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_instruction(if_instruction), .if_pc(if_pc),
    .if_pcplus4(if_pcplus4), .PCOutput(PCOutput)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  // Reference model state
  ent_t        m_fifo[$];
  logic [31:0] m_live[$];
  int          m_drop;
  logic [31:0] m_pc;
  bit          m_known;

  // Memory model
  logic [31:0] mem_q[$];
  int          mem_due[$];
  int          cyc;
  int          mem_lat;
  bit          lat_rand, rdy_rand;

  // Sampled DUT outputs and delivery log
  logic        s_req_valid, s_if_valid;
  logic [31:0] s_req_addr, s_if_pc, s_if_ins, s_if_p4, s_pcout;
  logic [31:0] d_pc[$], d_ins[$], d_p4[$];
  int          d_cyc[$];
  int          r;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h8C01_0000;
      32'h0000_0004: return 32'h8C02_0004;
      32'h0000_0008: return 32'h0022_1820;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    d_pc.delete(); d_ins.delete(); d_p4.delete(); d_cyc.delete();
  endtask

  // One clock cycle: drive at negedge, check mid-low-phase, update at posedge.
  task automatic step(input bit a_rst, input bit a_pcw, input bit a_ifw,
                      input bit a_redir, input logic [31:0] a_rpc);
    bit   rsp_now, byp, ev, pop, ereq, got;
    ent_t he, e;
    int   tot, d;
    resetManual    = a_rst;
    PCWrite        = a_pcw;
    IF_ID_Write    = a_ifw;
    redirect_valid = a_redir;
    redirect_pc    = a_rpc;
    imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    rsp_now        = (mem_q.size() > 0) && (mem_due[0] <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(mem_q[0]) : $urandom();
    #1;
    byp = 1'b0;
`ifdef IF_FETCH_RSP_BYPASS_EN
    byp = a_rst && !a_redir && (m_fifo.size() == 0) && rsp_now &&
          (m_drop == 0) && (m_live.size() > 0);
`endif
    ev = (m_fifo.size() > 0) || byp;
    he = '0;
    if (byp) begin
      he.pc  = m_live[0];
      he.ins = imem_rsp_data;
    end else if (m_fifo.size() > 0) begin
      he = m_fifo[0];
    end
    pop  = ev && a_ifw;
    ereq = a_rst && a_pcw && !a_redir &&
           ((m_fifo.size() + m_live.size() - int'(pop)) < 2);

    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_if_valid  = if_valid;
    s_if_pc     = if_pc;
    s_if_ins    = if_instruction;
    s_if_p4     = if_pcplus4;
    s_pcout     = PCOutput;

    if (m_known) begin
      check("req_valid", 32'(s_req_valid), 32'(ereq));
      check("req_addr", s_req_addr, m_pc);
      check("pc_output", s_pcout, m_pc);
      check("if_valid", 32'(s_if_valid), 32'(ev));
      if (ev) begin
        check("if_pc", s_if_pc, he.pc);
        check("if_instruction", s_if_ins, he.ins);
        check("if_pcplus4", s_if_p4, he.pc + 32'd4);
      end
    end
    if (s_if_valid && a_ifw && a_rst && !a_redir) begin
      d_pc.push_back(s_if_pc);
      d_ins.push_back(s_if_ins);
      d_p4.push_back(s_if_p4);
      d_cyc.push_back(cyc);
    end

    @(posedge clk);
    if (!a_rst) begin
      m_fifo.delete(); m_live.delete();
      m_drop  = 0;
      m_pc    = RST_PC;
      m_known = 1'b1;
    end else if (a_redir) begin
      tot = m_drop + m_live.size();
      if (rsp_now && tot > 0) tot--;
      m_drop = (tot > 2) ? 2 : tot;
      m_fifo.delete(); m_live.delete();
      m_pc = {a_rpc[31:2], 2'b00};
    end else begin
      got = 1'b0;
      e   = '0;
      if (rsp_now) begin
        if (m_drop > 0) m_drop--;
        else if (m_live.size() > 0) begin
          e.pc  = m_live.pop_front();
          e.ins = imem_rsp_data;
          got   = 1'b1;
        end
      end
      if (pop) begin
        if (byp) got = 1'b0;
        else void'(m_fifo.pop_front());
      end
      if (got) m_fifo.push_back(e);
      if (ereq && imem_req_ready) begin
        m_live.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    // Memory side reacts to what the DUT actually did.
    if (rsp_now) begin
      void'(mem_q.pop_front());
      void'(mem_due.pop_front());
    end
    if (s_req_valid && imem_req_ready) begin
      d = cyc + (lat_rand ? int'($urandom_range(1, 3)) : mem_lat);
      if (mem_due.size() > 0 && d <= mem_due[$]) d = mem_due[$] + 1;
      mem_q.push_back(s_req_addr);
      mem_due.push_back(d);
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    resetManual = 1'b0; PCWrite = 1'b0; IF_ID_Write = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    cyc = 0; mem_lat = 1; lat_rand = 1'b0; rdy_rand = 1'b0;
    m_known = 1'b0; m_drop = 0; m_pc = RST_PC; r = 0;
    @(negedge clk);

    // Reset values
    step(0, 1, 1, 0, 32'h0);
    step(0, 1, 1, 0, 32'h0);
    check("rst_if_valid", 32'(s_if_valid), 32'd0);
    check("rst_req_valid", 32'(s_req_valid), 32'd0);
    check("rst_if_instruction", s_if_ins, 32'd0);
    check("rst_if_pc", s_if_pc, 32'd0);
    check("rst_if_pcplus4", s_if_p4, 32'd4);
    check("rst_pc_output", s_pcout, RST_PC);

    // First fetches after reset release
    step(1, 1, 1, 0, 32'h0);
    check("boot_req_valid0", 32'(s_req_valid), 32'd1);
    check("boot_req_addr0", s_req_addr, 32'h40);
    step(1, 1, 1, 0, 32'h0);
    check("boot_req_addr1", s_req_addr, 32'h44);
    step(1, 1, 1, 0, 32'h0);
    check("boot_req_valid2", 32'(s_req_valid), 32'd1);
    check("boot_req_addr2", s_req_addr, 32'h48);

    // Streaming from 0 with a 1-cycle memory
    r = cyc;
    step(1, 1, 1, 1, 32'h0);
    clear_log();
    repeat (6) step(1, 1, 1, 0, 32'h0);
    check("stream_count", 32'(d_pc.size() >= 3), 32'd1);
    if (d_pc.size() >= 3) begin
      check("stream_pc0", d_pc[0], 32'h0);
      check("stream_pc1", d_pc[1], 32'h4);
      check("stream_pc2", d_pc[2], 32'h8);
      check("stream_ins0", d_ins[0], 32'h8C01_0000);
      check("stream_ins1", d_ins[1], 32'h8C02_0004);
      check("stream_ins2", d_ins[2], 32'h0022_1820);
      check("stream_p4_0", d_p4[0], 32'h4);
      check("stream_p4_1", d_p4[1], 32'h8);
      check("stream_p4_2", d_p4[2], 32'hC);
      check("stream_gap1", 32'(d_cyc[1] - d_cyc[0]), 32'd1);
      check("stream_gap2", 32'(d_cyc[2] - d_cyc[1]), 32'd1);
      check("stream_latency", 32'(d_cyc[0] - r), 32'(FIRST_LAT));
    end

    // Stall with downstream not ready and PCWrite low
    step(1, 1, 1, 1, 32'h0);
    clear_log();
    for (int i = 0; i < 6 && d_pc.size() == 0; i++) step(1, 1, 1, 0, 32'h0);
    check("stall_first_pc", (d_pc.size() > 0) ? d_pc[0] : 32'hDEAD_BEEF, 32'h0);
    clear_log();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 32'h0);
      check("stall_if_valid", 32'(s_if_valid), 32'd1);
      check("stall_if_pc", s_if_pc, 32'h4);
      check("stall_req_valid", 32'(s_req_valid), 32'd0);
      check("stall_pc_output", s_pcout, STALL_PC);
    end
    step(1, 1, 1, 0, 32'h0);
    check("resume_req_valid", 32'(s_req_valid), 32'd1);
    check("resume_req_addr", s_req_addr, STALL_PC);
    repeat (5) step(1, 1, 1, 0, 32'h0);
    check("resume_count", 32'(d_pc.size() >= 4), 32'd1);
    if (d_pc.size() >= 4) begin
      for (int k = 0; k < 4; k++) check("resume_seq", d_pc[k], 32'(4 + 4 * k));
    end

    // Redirect with two requests outstanding
    mem_lat = 3;
    step(1, 1, 1, 1, 32'h200);
    step(1, 1, 1, 0, 32'h0);
    step(1, 1, 1, 0, 32'h0);
    step(1, 1, 1, 1, 32'h0000_0103);
    clear_log();
    step(1, 1, 1, 0, 32'h0);
    check("redir_req_valid", 32'(s_req_valid), 32'd1);
    check("redir_req_addr", s_req_addr, 32'h100);
    repeat (8) step(1, 1, 1, 0, 32'h0);
    check("redir_first_pc", (d_pc.size() > 0) ? d_pc[0] : 32'hDEAD_BEEF, 32'h100);

    // Redirect colliding with pop and response
    mem_lat = 1;
    step(1, 1, 1, 1, 32'h0);
    repeat (5) step(1, 1, 1, 0, 32'h0);
    step(1, 1, 1, 1, 32'h300);
    check("coll_pre_if_valid", 32'(s_if_valid), 32'd1);
    step(1, 1, 1, 0, 32'h0);
    check("coll_if_valid", 32'(s_if_valid), 32'd0);
    check("coll_pc_output", s_pcout, 32'h300);
    clear_log();
    repeat (5) step(1, 1, 1, 0, 32'h0);
    check("coll_first_pc", (d_pc.size() > 0) ? d_pc[0] : 32'hDEAD_BEEF, 32'h300);

    // PC wrap
    step(1, 1, 1, 1, 32'hFFFF_FFFC);
    clear_log();
    step(1, 1, 1, 0, 32'h0);
    check("wrap_req_addr0", s_req_addr, 32'hFFFF_FFFC);
    step(1, 1, 1, 0, 32'h0);
    check("wrap_req_valid1", 32'(s_req_valid), 32'd1);
    check("wrap_req_addr1", s_req_addr, 32'h0);
    repeat (4) step(1, 1, 1, 0, 32'h0);
    check("wrap_count", 32'(d_pc.size() >= 2), 32'd1);
    if (d_pc.size() >= 2) begin
      check("wrap_pc0", d_pc[0], 32'hFFFF_FFFC);
      check("wrap_p4_0", d_p4[0], 32'h0);
      check("wrap_pc1", d_pc[1], 32'h0);
    end

    // Randomized traffic with a mid-run reset
    lat_rand = 1'b1;
    rdy_rand = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        step(0, 1, 1, 0, 32'h0);
        step(0, 1, 1, 0, 32'h0);
        check("midrst_pc_output", s_pcout, RST_PC);
        check("midrst_if_valid", 32'(s_if_valid), 32'd0);
        for (int j = 0; j < 8; j++) step(1, 0, ($urandom_range(0, 1) != 0), 0, 32'h0);
      end
      step(1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 29) == 0), $urandom());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
